// File: rtl/cmp_lgez_serial.sv
// Bit-serial magnitude comparator: one LGEZ cell is stepped over the operands LSB first.
// The result is returned through a valid/ack handshake.
module cmp_lgez_serial #(
  parameter int p_WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [p_WIDTH-1:0] iv_x,
  input  logic [p_WIDTH-1:0] iv_y,
  input  logic               i_signed,
  input  logic               i_ack,
  output logic               o_ready,
  output logic               o_busy,
  output logic               o_valid,
  output logic               o_gt,
  output logic               o_lt,
  output logic               o_eq,
  output logic               o_zx,
  output logic               o_zy
);

  localparam int CW = (p_WIDTH > 1) ? $clog2(p_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(p_WIDTH - 1);

  generate
    if (p_WIDTH < 2) begin : g_bad_width
      $error("cmp_lgez_serial: p_WIDTH must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [p_WIDTH-1:0] x_q, y_q;
  logic               sgn_q;
  logic               rx, ry, zx, zy;
  logic [CW-1:0]      cnt;

  logic last_bit, swap, mx, my;
  logic rx_nxt, ry_nxt, zx_nxt, zy_nxt;

  // A differing bit at higher significance overrides whatever verdict was carried in.
  function automatic logic [1:0] lgez_cell(input logic lx, input logic ly,
                                           input logic bx, input logic by);
    return (bx ^ by) ? {bx, by} : {lx, ly};
  endfunction

  assign last_bit = (cnt == LAST_BIT);

  always_comb begin
    // Sign bits are swapped so a negative X (sign 1) reads as the smaller operand.
    swap             = sgn_q & last_bit;
    mx               = swap ? y_q[0] : x_q[0];
    my               = swap ? x_q[0] : y_q[0];
    {rx_nxt, ry_nxt} = lgez_cell(rx, ry, mx, my);
    zx_nxt           = zx & ~x_q[0];
    zy_nxt           = zy & ~y_q[0];
  end

  // NOTE: every path through a combinational block must assign each output, so the
  // default goes first; otherwise the tool infers a latch to hold the old value.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start)  state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    if (i_ack)    state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments, so every register samples
  // pre-edge values no matter how the statements are ordered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_q   <= '0;
      y_q   <= '0;
      sgn_q <= 1'b0;
      rx    <= 1'b0;
      ry    <= 1'b0;
      zx    <= 1'b0;
      zy    <= 1'b0;
      cnt   <= '0;
      o_gt  <= 1'b0;
      o_lt  <= 1'b0;
      o_eq  <= 1'b0;
      o_zx  <= 1'b0;
      o_zy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            x_q   <= iv_x;
            y_q   <= iv_y;
            sgn_q <= i_signed;
            rx    <= 1'b0;
            ry    <= 1'b0;
            zx    <= 1'b1;
            zy    <= 1'b1;
            cnt   <= '0;
          end
        end
        RUN: begin
          x_q <= x_q >> 1;
          y_q <= y_q >> 1;
          rx  <= rx_nxt;
          ry  <= ry_nxt;
          zx  <= zx_nxt;
          zy  <= zy_nxt;
          if (last_bit) begin
            o_gt <= rx_nxt & ~ry_nxt;
            o_lt <= ~rx_nxt & ry_nxt;
            o_eq <= ~(rx_nxt ^ ry_nxt);
            o_zx <= zx_nxt;
            o_zy <= zy_nxt;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_ready = (state == IDLE);
  assign o_busy  = (state == RUN);
  assign o_valid = (state == DONE);

endmodule

// File: tb/tb_cmp_lgez_serial.sv
// Directed bench for cmp_lgez_serial: an 8-bit instance for handshake/reset scenarios
// and a 2-bit instance swept exhaustively against a signed/unsigned integer model.
module tb_cmp_lgez_serial;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic       start8 = 1'b0, sgn8 = 1'b0, ack8 = 1'b0;
  logic [7:0] x8 = '0, y8 = '0;
  logic       ready8, busy8, valid8, gt8, lt8, eq8, zx8, zy8;

  logic       start2 = 1'b0, sgn2 = 1'b0, ack2 = 1'b0;
  logic [1:0] x2 = '0, y2 = '0;
  logic       ready2, busy2, valid2, gt2, lt2, eq2, zx2, zy2;

  logic [4:0] res8, res2;
  logic [2:0] stat8, stat2;
  assign res8  = {gt8, lt8, eq8, zx8, zy8};
  assign res2  = {gt2, lt2, eq2, zx2, zy2};
  assign stat8 = {ready8, busy8, valid8};
  assign stat2 = {ready2, busy2, valid2};

  cmp_lgez_serial #(.p_WIDTH(8)) u_dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start8), .iv_x(x8), .iv_y(y8),
    .i_signed(sgn8), .i_ack(ack8), .o_ready(ready8), .o_busy(busy8),
    .o_valid(valid8), .o_gt(gt8), .o_lt(lt8), .o_eq(eq8), .o_zx(zx8), .o_zy(zy8)
  );

  cmp_lgez_serial #(.p_WIDTH(2)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .iv_x(x2), .iv_y(y2),
    .i_signed(sgn2), .i_ack(ack2), .o_ready(ready2), .o_busy(busy2),
    .o_valid(valid2), .o_gt(gt2), .o_lt(lt2), .o_eq(eq2), .o_zx(zx2), .o_zy(zy2)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmp8(input logic [7:0] x, input logic [7:0] y, input logic s);
    x8 = x; y8 = y; sgn8 = s; start8 = 1'b1;
    step();
    start8 = 1'b0;
  endtask

  task automatic wait_valid8(input string tag, output int lat);
    lat = 0;
    while (!valid8 && lat < 40) begin
      step();
      lat++;
    end
    check({tag, "_timeout"}, 8'(valid8), 8'd1);
  endtask

  task automatic compare8(input string tag, input logic [7:0] x, input logic [7:0] y,
                          input logic s, input logic [4:0] exp);
    int lat;
    start_cmp8(x, y, s);
    wait_valid8(tag, lat);
    check(tag, 8'(res8), 8'(exp));
    ack8 = 1'b1;
    step();
    ack8 = 1'b0;
    check({tag, "_ready"}, 8'(stat8), 8'b100);
  endtask

  int lat, d, xv, yv;
  logic [4:0] e2;

  initial begin
    // Reset state before any clock edge.
    #2;
    check("reset_status", 8'(stat8), 8'b100);
    check("reset_results", 8'(res8), 8'd0);
    check("reset_status_w2", 8'(stat2), 8'b100);
    #10 rst_n = 1'b1;
    step();

    // Latency: accept edge plus 8 bit edges = 9 edges; ack held high.
    ack8 = 1'b1;
    start_cmp8(8'h5A, 8'h5A, 1'b0);
    check("accept_status", 8'(stat8), 8'b010);
    wait_valid8("lat_5a", lat);
    check("latency_edges_after_accept", 8'(lat), 8'd8);
    check("eq_5a", 8'(res8), 8'b00100);
    step();
    check("ready_after_ack", 8'(stat8), 8'b100);
    ack8 = 1'b0;

    // Signed vs unsigned.
    compare8("u_80_7f", 8'h80, 8'h7F, 1'b0, 5'b10000);
    compare8("s_80_7f", 8'h80, 8'h7F, 1'b1, 5'b01000);
    compare8("s_ff_01", 8'hFF, 8'h01, 1'b1, 5'b01000);
    compare8("u_ff_01", 8'hFF, 8'h01, 1'b0, 5'b10000);

    // Zero flags.
    compare8("zero_both", 8'h00, 8'h00, 1'b0, 5'b00111);
    compare8("zero_y", 8'h01, 8'h00, 1'b0, 5'b10001);

    // Handshake hold with ignored starts and operand changes after accept.
    start_cmp8(8'h10, 8'h20, 1'b0);
    repeat (3) step();
    check("hold_busy", 8'(stat8), 8'b010);
    x8 = 8'hFF; y8 = 8'h00; start8 = 1'b1;
    step();
    start8 = 1'b0;
    wait_valid8("hold", lat);
    check("hold_latency", 8'(lat + 4), 8'd8);
    check("hold_result", 8'(res8), 8'b01000);
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("hold_result_stable", 8'(res8), 8'b01000);
      check("hold_status_stable", 8'(stat8), 8'b001);
      step();
    end
    ack8 = 1'b1;
    step();
    ack8 = 1'b0;
    check("hold_ready_after_ack", 8'(stat8), 8'b100);
    step();
    step();
    check("no_queued_compare", 8'(stat8), 8'b100);

    // Reset between the edges that process bits 2 and 3.
    start_cmp8(8'h33, 8'h12, 1'b1);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check("midrun_reset_status", 8'(stat8), 8'b100);
    check("midrun_reset_results", 8'(res8), 8'd0);
    #2 rst_n = 1'b1;
    step();
    check("after_reset_idle", 8'(stat8), 8'b100);
    compare8("after_reset_3_5", 8'd3, 8'd5, 1'b0, 5'b01000);

    // Exhaustive 2-bit sweep against an integer model.
    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < 4; x++) begin
        for (int y = 0; y < 4; y++) begin
          xv = (s == 1 && x >= 2) ? x - 4 : x;
          yv = (s == 1 && y >= 2) ? y - 4 : y;
          e2 = {xv > yv, xv < yv, xv == yv, x == 0, y == 0};
          x2 = 2'(x); y2 = 2'(y); sgn2 = s[0]; start2 = 1'b1;
          step();
          start2 = 1'b0;
          lat = 0;
          while (!valid2 && lat < 20) begin
            step();
            lat++;
          end
          check("w2_latency", 8'(lat), 8'd2);
          check($sformatf("w2_s%0d_x%0d_y%0d", s, x, y), 8'(res2), 8'(e2));
          check("w2_onehot", 8'($countones(res2[4:2])), 8'd1);
          d = int'($urandom_range(0, 3));
          repeat (d) step();
          check("w2_valid_held", 8'(stat2), 8'b001);
          ack2 = 1'b1;
          step();
          ack2 = 1'b0;
          check("w2_ready", 8'(stat2), 8'b100);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
